// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// Module   : mem_ctrl_pkg
// Brief    : Shared widths, FSM/owner encodings and size helper for mem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

    localparam int ADDR_LEN = 32;
    localparam int REG_LEN  = 32;

    // Address bits [17:16] of the memory-mapped I/O window at 0x30000.
    localparam logic [1:0] IO_REGION_HI = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // Sizes outside 1..4 fall back to a full word.
    function automatic logic [2:0] norm_size(input logic [2:0] n);
        return ((n == 3'd0) || (n > 3'd4)) ? 3'd4 : n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl_arb.sv
// ============================================================================
// Module   : mem_ctrl_arb
// Brief    : Combinational IF/MEM arbiter; MEM has priority, I/O stores may
//            be held off by a full I/O buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  state_t       state,
    input  logic         if_req,
    input  logic         mem_load,
    input  logic         mem_store,
    input  logic [1:0]   mem_region,
    input  logic         io_full,
    output logic         grant,
    output owner_t       owner
);

    logic w_mem_req;
    logic w_io_hold;

    assign w_mem_req = mem_load | mem_store;
    // A held-off store keeps MEM owning the port, so IF cannot slip in.
    assign w_io_hold = mem_store && io_full && (mem_region == IO_REGION_HI);

    always_comb begin
        grant = 1'b0;
        owner = OWN_IF;
        if (w_mem_req) begin
            owner = OWN_MEM;
        end
        if (state == IDLE) begin
            grant = w_mem_req ? !w_io_hold : if_req;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module   : mem_ctrl
// Brief    : Byte-serial RAM controller for IF fetches and MEM loads/stores.
// Optional : MEM_CTRL_IO_STALL_EN adds io_buffer_full and I/O store stalls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                if_req,
    input  logic [ADDR_LEN-1:0] if_addr,
    output logic [REG_LEN-1:0]  if_data,
    output logic                if_done,
    input  logic                mem_load,
    input  logic                mem_store,
    input  logic [ADDR_LEN-1:0] mem_addr,
    input  logic [2:0]          mem_nbytes,
    input  logic [REG_LEN-1:0]  mem_wdata,
    output logic [REG_LEN-1:0]  mem_rdata,
    output logic                mem_done,
    input  logic [7:0]          ram_din,
    output logic [7:0]          ram_dout,
    output logic [ADDR_LEN-1:0] ram_a,
    output logic                ram_wr
`ifdef MEM_CTRL_IO_STALL_EN
    ,
    input  logic                io_buffer_full
`endif
);

    state_t                r_state;
    state_t                w_state_nxt;
    owner_t                r_owner;
    owner_t                w_owner;
    logic                  w_grant;
    logic                  r_store;
    logic [2:0]            r_size;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_nxt;
    logic [1:0]            w_cap_idx;
    logic [ADDR_LEN-1:0]   r_base;
    logic [ADDR_LEN-1:0]   w_addr;
    logic [REG_LEN-1:0]    r_wdata;
    logic [REG_LEN-1:0]    r_data;
    logic                  w_io_full;
    logic                  w_io_block;

`ifdef MEM_CTRL_IO_STALL_EN
    assign w_io_full = io_buffer_full;
`else
    assign w_io_full = 1'b0;
`endif

    mem_ctrl_arb u_arb (
        .state      (r_state),
        .if_req     (if_req),
        .mem_load   (mem_load),
        .mem_store  (mem_store),
        .mem_region (mem_addr[17:16]),
        .io_full    (w_io_full),
        .grant      (w_grant),
        .owner      (w_owner)
    );

    assign w_addr     = r_base + {29'd0, r_cnt};
    assign w_io_block = w_io_full && (w_addr[17:16] == IO_REGION_HI);
    // Byte returned now belongs to the address issued one step earlier.
    assign w_cap_idx  = r_cnt[1:0] - 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else if (rdy) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = 3'd0;
                end
            end
            BUSY: begin
                if (r_store) begin
                    if (!w_io_block) begin
                        w_cnt_nxt = r_cnt + 3'd1;
                        if (r_cnt == r_size - 3'd1) begin
                            w_state_nxt = DONE;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                    if (r_cnt == r_size) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_IF;
            r_store <= 1'b0;
            r_size  <= 3'd0;
            r_base  <= '0;
            r_wdata <= '0;
            r_data  <= '0;
        end else if (rdy) begin
            if ((r_state == IDLE) && w_grant) begin
                r_owner <= w_owner;
                r_store <= (w_owner == OWN_MEM) && mem_store;
                r_size  <= (w_owner == OWN_MEM) ? norm_size(mem_nbytes) : 3'd4;
                r_base  <= (w_owner == OWN_MEM) ? mem_addr : if_addr;
                r_wdata <= mem_wdata;
                r_data  <= '0;
            end else if ((r_state == BUSY) && !r_store && (r_cnt != 3'd0)) begin
                r_data[{w_cap_idx, 3'b000} +: 8] <= ram_din;
            end
        end
    end

    always_comb begin
        ram_a    = '0;
        ram_dout = 8'd0;
        ram_wr   = 1'b0;
        if (r_state == BUSY) begin
            ram_a = w_addr;
            if (r_store) begin
                ram_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                ram_wr   = rdy && !w_io_block;
            end
        end
    end

    assign if_done   = (r_state == DONE) && (r_owner == OWN_IF);
    assign mem_done  = (r_state == DONE) && (r_owner == OWN_MEM);
    assign if_data   = if_done  ? r_data : '0;
    assign mem_rdata = mem_done ? r_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// Module   : tb_mem_ctrl
// Brief    : Self-checking bench for mem_ctrl (vector table plus hand-written
//            arbitration, rdy-freeze, reset and I/O-stall sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_load;
    logic        mem_store;
    logic [31:0] mem_addr;
    logic [2:0]  mem_nbytes;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
`ifdef MEM_CTRL_IO_STALL_EN
    logic        io_buffer_full;
`endif

    logic [7:0] ram [0:4095];

    typedef struct {
        bit          is_if;
        bit          ld;
        bit          st;
        logic [31:0] addr;
        logic [2:0]  n;
        logic [31:0] wdata;
        logic [31:0] rbytes;
        logic [31:0] exp_data;
        int          nw;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        bit          own_if;
        bit          chk;
        logic [31:0] data;
    } done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];
    vec_t  vecs[13];

    int total = 0;
    int bad   = 0;

    mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_data    (if_data),
        .if_done    (if_done),
        .mem_load   (mem_load),
        .mem_store  (mem_store),
        .mem_addr   (mem_addr),
        .mem_nbytes (mem_nbytes),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_done   (mem_done),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .ram_a      (ram_a),
        .ram_wr     (ram_wr)
`ifdef MEM_CTRL_IO_STALL_EN
        ,
        .io_buffer_full (io_buffer_full)
`endif
    );

    always #5 clk = ~clk;

    // Address in cycle k, data in cycle k+1; output held while rdy is low.
    always @(posedge clk) begin
        if (rdy) ram_din <= ram[ram_a[11:0]];
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock: advance to the next falling edge and score writes and done pulses.
    task automatic tick();
        wr_t   w;
        done_t d;
        @(negedge clk);
        if (ram_wr) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_wr", ram_a, 32'hFFFF_FFFF);
            end else begin
                w = exp_wr.pop_front();
                chk("wr_addr", ram_a, w.addr);
                chk("wr_data", {24'd0, ram_dout}, {24'd0, w.data});
            end
        end
        if (if_done || mem_done) begin
            if (exp_done.size() == 0) begin
                chk("unexpected_done", {30'd0, if_done, mem_done}, 32'd0);
            end else begin
                d = exp_done.pop_front();
                chk("done_owner", {30'd0, if_done, mem_done}, {30'd0, d.own_if, !d.own_if});
                if (d.chk) chk("done_data", d.own_if ? if_data : mem_rdata, d.data);
            end
        end
    endtask

    task automatic wait_done(input bit want_if, output int lat);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) tick();
            if (want_if ? if_done : mem_done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic drop_reqs();
        if_req    = 1'b0;
        mem_load  = 1'b0;
        mem_store = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        if (!v.st) begin
            for (int i = 0; i < 4; i++) begin
                logic [31:0] a;
                a = v.addr + i;
                ram[a[11:0]] = v.rbytes[8*i +: 8];
            end
        end else begin
            for (int i = 0; i < v.nw; i++) exp_wr.push_back('{v.addr + i, v.wdata[8*i +: 8]});
        end
        exp_done.push_back('{v.is_if, !v.st, v.exp_data});
        if_req     = v.is_if;
        if_addr    = v.addr;
        mem_load   = v.ld;
        mem_store  = v.st;
        mem_addr   = v.addr;
        mem_nbytes = v.n;
        mem_wdata  = v.wdata;
        wait_done(v.is_if, lat);
        chk({name, "_lat"}, lat, v.lat);
        drop_reqs();
        tick();
        chk({name, "_idle_a"}, ram_a, 32'd0);
    endtask

    initial begin
        int lat;
        clk        = 1'b0;
        rst        = 1'b1;
        rdy        = 1'b1;
        if_addr    = '0;
        mem_addr   = '0;
        mem_nbytes = 3'd0;
        mem_wdata  = '0;
        drop_reqs();
`ifdef MEM_CTRL_IO_STALL_EN
        io_buffer_full = 1'b0;
`endif
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;

        tick();
        tick();
        chk("reset_ram_a", ram_a, 32'd0);
        chk("reset_flags", {28'd0, ram_wr, if_done, mem_done, |ram_dout}, 32'd0);
        chk("reset_data", if_data | mem_rdata, 32'd0);
        rst = 1'b0;
        tick();

        //            if  ld  st  addr           n     wdata          rbytes         exp_data       nw lat
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 3'd4, 32'h0,         32'h0010_0513, 32'h0010_0513, 0, 6};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0300, 3'd1, 32'h0,         32'hFFFF_FF80, 32'h0000_0080, 0, 3};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0400, 3'd2, 32'h0,         32'h9988_1234, 32'h0000_1234, 0, 4};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0200, 3'd4, 32'h0,         32'h1234_5678, 32'h1234_5678, 0, 6};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0500, 3'd3, 32'h0,         32'hDDCC_BBAA, 32'h00CC_BBAA, 0, 5};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0600, 3'd0, 32'h0,         32'h0BAD_F00D, 32'h0BAD_F00D, 0, 6};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0604, 3'd7, 32'h0,         32'h600D_CAFE, 32'h600D_CAFE, 0, 6};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 3'd4, 32'h0,         32'h4433_2211, 32'h4433_2211, 0, 6};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h0FFF_FFFF, 3'd2, 32'hDEAD_BEEF, 32'h0,         32'h0,         2, 3};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0700, 3'd4, 32'hCAFE_F00D, 32'h0,         32'h0,         4, 5};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 3'd1, 32'h0000_00A5, 32'h0,         32'h0,         1, 2};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h0000_0800, 3'd3, 32'h1122_3344, 32'h0,         32'h0,         3, 4};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h0000_0A00, 3'd1, 32'h0000_005A, 32'h0,         32'h0,         1, 2};

        for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // IF and MEM request together: MEM first, IF granted after DONE.
        exp_done.push_back('{1'b0, 1'b1, 32'h1234_5678});
        exp_done.push_back('{1'b1, 1'b1, 32'h0010_0513});
        if_req = 1'b1; if_addr = 32'h100;
        mem_load = 1'b1; mem_addr = 32'h200; mem_nbytes = 3'd4;
        wait_done(1'b0, lat);
        chk("arb_mem_lat", lat, 32'd6);
        chk("arb_no_if_yet", {31'd0, if_done}, 32'd0);
        mem_load = 1'b0;
        wait_done(1'b1, lat);
        chk("arb_if_lat", lat, 32'd7);
        drop_reqs();
        tick();

        // rdy low for three cycles in the middle of a fetch.
        exp_done.push_back('{1'b1, 1'b1, 32'h0010_0513});
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rdy_wr", {31'd0, ram_wr}, 32'd0);
            chk("rdy_a", ram_a, 32'h101);
        end
        rdy = 1'b1;
        wait_done(1'b1, lat);
        chk("rdy_lat", (lat < 0) ? lat : lat + 5, 32'd9);
        drop_reqs();
        tick();

        // Reset in the middle of a word store.
        exp_wr.push_back('{32'h900, 8'h44});
        exp_wr.push_back('{32'h901, 8'h33});
        mem_store = 1'b1; mem_addr = 32'h900; mem_nbytes = 3'd4; mem_wdata = 32'h1122_3344;
        tick();
        tick();
        rst = 1'b1;
        drop_reqs();
        #1;
        chk("rst_mid_a", ram_a, 32'd0);
        chk("rst_mid_flags", {28'd0, ram_wr, if_done, mem_done, |ram_dout}, 32'd0);
        chk("rst_mid_data", if_data | mem_rdata, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_vec(vecs[1], "post_rst");

`ifdef MEM_CTRL_IO_STALL_EN
        // I/O store held off by a full buffer; IF must not take its place.
        io_buffer_full = 1'b1;
        exp_wr.push_back('{32'h0003_0000, 8'h77});
        exp_done.push_back('{1'b0, 1'b0, 32'h0});
        mem_store = 1'b1; mem_addr = 32'h0003_0000; mem_nbytes = 3'd1; mem_wdata = 32'h77;
        if_req = 1'b1; if_addr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("io_stall_wr", {31'd0, ram_wr}, 32'd0);
            chk("io_stall_a", ram_a, 32'd0);
        end
        io_buffer_full = 1'b0;
        wait_done(1'b0, lat);
        chk("io_lat", lat, 32'd2);
        drop_reqs();
        tick();
`endif

        chk("wr_left", exp_wr.size(), 32'd0);
        chk("done_left", exp_done.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
